// File: rtl/lru_cache.sv
// lru_cache: fully associative cache with true-LRU replacement.
// A frontend lookup either hits (one-cycle response) or misses and fetches the
// line from the backend. The victim is the lowest-index invalid line, otherwise
// the line at the LRU position. A flush pulse invalidates every line.
// Optional build macro: LRU_CACHE_STATS_EN adds saturating hit_cnt/miss_cnt.
module lru_cache #(
  parameter int TAGS_WIDTH  = 48,
  parameter int CACHE_SIZE  = 512,
  parameter int CACHE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fe_addr_tvalid,
  output logic                  fe_addr_tready,
  input  logic [TAGS_WIDTH-1:0] fe_addr_tdata,
  output logic                  fe_data_tvalid,
  input  logic                  fe_data_tready,
  output logic [CACHE_SIZE-1:0] fe_data_tdata,
  output logic                  fe_data_thit,
  output logic                  be_addr_tvalid,
  input  logic                  be_addr_tready,
  output logic [TAGS_WIDTH-1:0] be_addr_tdata,
  input  logic                  be_data_tvalid,
  output logic                  be_data_tready,
  input  logic [CACHE_SIZE-1:0] be_data_tdata,
  input  logic                  flush
`ifdef LRU_CACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int IDX_W = $clog2(CACHE_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    MISS_REQ  = 2'd2,
    MISS_WAIT = 2'd3
  } state_t;

  state_t                 state_reg;
  logic [CACHE_DEPTH-1:0] valid_reg;
  logic [IDX_W-1:0]       order_reg  [CACHE_DEPTH];
  logic [IDX_W-1:0]       order_next [CACHE_DEPTH];
  logic [TAGS_WIDTH-1:0]  tag_mem    [CACHE_DEPTH];
  logic [CACHE_SIZE-1:0]  data_mem   [CACHE_DEPTH];
  logic                   flush_pend_reg;
  logic                   addr_rdy_reg;

  logic [CACHE_DEPTH-1:0] match_vec;
  logic [CACHE_DEPTH-1:0] seen_before;
  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic [IDX_W-1:0]       victim_idx;
  logic [IDX_W-1:0]       promote_idx;
  logic                   lookup_fire;
  logic                   fill_fire;

  // The registered ready is additionally masked by a same-cycle flush so that
  // flush always wins over a concurrent lookup.
  assign fe_addr_tready = addr_rdy_reg & ~flush & ~flush_pend_reg & (state_reg == IDLE);
  assign lookup_fire    = fe_addr_tvalid & fe_addr_tready;
  assign fill_fire      = (state_reg == MISS_WAIT) & be_data_tvalid & be_data_tready;
  assign hit            = |match_vec;
  assign promote_idx    = (state_reg == MISS_WAIT) ? victim_idx : hit_idx;

  // Per-line tag compare, and the promoted order: positions up to the promoted
  // slot shift down by one, positions behind it stay put.
  for (genvar gi = 0; gi < CACHE_DEPTH; gi++) begin : g_line
    assign match_vec[gi] = valid_reg[gi] && (tag_mem[gi] == fe_addr_tdata);
    if (gi == 0) begin : g_mru
      assign order_next[gi] = promote_idx;
    end else begin : g_rest
      assign order_next[gi] = seen_before[gi] ? order_reg[gi] : order_reg[gi-1];
    end
  end

  // Marks positions that lie after the position holding the promoted slot.
  always_comb begin
    seen_before = '0;
    for (int i = 1; i < CACHE_DEPTH; i++) begin
      seen_before[i] = seen_before[i-1] | (order_reg[i-1] == promote_idx);
    end
  end

  // Encode the single matching line (tags are unique among valid lines).
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < CACHE_DEPTH; i++) begin
      if (match_vec[i]) hit_idx = IDX_W'(i);
    end
  end

  // Victim choice: lowest-index invalid line, otherwise the LRU slot.
  always_comb begin
    victim_idx = order_reg[CACHE_DEPTH-1];
    for (int i = CACHE_DEPTH - 1; i >= 0; i--) begin
      if (!valid_reg[i]) victim_idx = IDX_W'(i);
    end
  end

  // Line storage: written only when backend fill data is accepted.
  always_ff @(posedge clk) begin
    if (fill_fire) begin
      tag_mem[victim_idx]  <= be_addr_tdata;
      data_mem[victim_idx] <= be_data_tdata;
    end
  end

  // Controller: lookup, miss/fill sequencing, LRU order, flush and handshakes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      valid_reg      <= '0;
      for (int i = 0; i < CACHE_DEPTH; i++) order_reg[i] <= IDX_W'(i);
      flush_pend_reg <= 1'b0;
      addr_rdy_reg   <= 1'b0;
      fe_data_tvalid <= 1'b0;
      fe_data_thit   <= 1'b0;
      fe_data_tdata  <= '0;
      be_addr_tvalid <= 1'b0;
      be_addr_tdata  <= '0;
      be_data_tready <= 1'b0;
    end else begin
      // A flush seen mid-transaction is remembered and applied back in IDLE.
      if (flush && (state_reg != IDLE)) flush_pend_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (flush || flush_pend_reg) begin
            valid_reg      <= '0;
            for (int i = 0; i < CACHE_DEPTH; i++) order_reg[i] <= IDX_W'(i);
            flush_pend_reg <= 1'b0;
            addr_rdy_reg   <= 1'b1;
          end else if (lookup_fire) begin
            addr_rdy_reg <= 1'b0;
            if (hit) begin
              fe_data_tdata  <= data_mem[hit_idx];
              fe_data_thit   <= 1'b1;
              fe_data_tvalid <= 1'b1;
              order_reg      <= order_next;
              state_reg      <= RESP;
            end else begin
              be_addr_tdata  <= fe_addr_tdata;
              be_addr_tvalid <= 1'b1;
              state_reg      <= MISS_REQ;
            end
          end else begin
            addr_rdy_reg <= 1'b1;
          end
        end
        RESP: begin
          if (fe_data_tready) begin
            fe_data_tvalid <= 1'b0;
            fe_data_thit   <= 1'b0;
            addr_rdy_reg   <= !(flush_pend_reg || flush);
            state_reg      <= IDLE;
          end
        end
        MISS_REQ: begin
          if (be_addr_tready) begin
            be_addr_tvalid <= 1'b0;
            be_data_tready <= 1'b1;
            state_reg      <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (fill_fire) begin
            be_data_tready         <= 1'b0;
            valid_reg[victim_idx]  <= 1'b1;
            order_reg              <= order_next;
            fe_data_tdata          <= be_data_tdata;
            fe_data_thit           <= 1'b0;
            fe_data_tvalid         <= 1'b1;
            state_reg              <= RESP;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef LRU_CACHE_STATS_EN
  // Saturating statistics, counted on accepted lookups; flush leaves them alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (lookup_fire) begin
      if (hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/lru_cache.md
LRU_CACHE -- requirements
Module: lru_cache

Interface
REQ-001 SHALL have parameter TAGS_WIDTH, default 48: lookup tag / backend address width.
REQ-002 SHALL have parameter CACHE_SIZE, default 512: cache-line data width in bits.
REQ-003 SHALL have parameter CACHE_DEPTH, default 8: line count; power of two, 2..64; IDX_W = log2(CACHE_DEPTH).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 fe_addr_tvalid / fe_addr_tready / fe_addr_tdata  in/out/in  1/1/TAGS_WIDTH  frontend lookup request.
REQ-007 fe_data_tvalid / fe_data_tready / fe_data_tdata  out/in/out  1/1/CACHE_SIZE  frontend line response.
REQ-008 fe_data_thit  out  1  response was a hit; valid with fe_data_tvalid.
REQ-009 be_addr_tvalid / be_addr_tready / be_addr_tdata  out/in/out  1/1/TAGS_WIDTH  backend fill request.
REQ-010 be_data_tvalid / be_data_tready / be_data_tdata  in/out/in  1/1/CACHE_SIZE  backend fill data.
REQ-011 flush  in  1  single-cycle pulse; invalidates all lines.
REQ-012 hit_cnt / miss_cnt  out  32/32  statistics counters; present only with LRU_CACHE_STATS_EN.

Function
REQ-013 Storage SHALL be fully associative: per line a valid bit, tag, data; plus an order array of CACHE_DEPTH slot indices, position 0 = MRU, position CACHE_DEPTH-1 = LRU.
REQ-014 Handshake SHALL be tvalid&tready; a tvalid output SHALL hold, with tdata stable, until accepted.
REQ-015 FSM states: IDLE, RESP, MISS_REQ, MISS_WAIT.
REQ-016 fe_addr_tready SHALL be 1 only in IDLE with no flush pending or asserted this cycle.
REQ-017 IDLE, request accepted at cycle T: hit = any valid line with tag equal to fe_addr_tdata; at most one line matches.
REQ-018 Hit: data and thit=1 registered; RESP with fe_data_tvalid=1 at T+1; hit slot promoted to MRU at T+1.
REQ-019 Promotion: slot at position p moves to position 0; positions 0..p-1 shift down by one; positions >p unchanged.
REQ-020 Miss: tag latched; MISS_REQ with be_addr_tvalid=1, be_addr_tdata=tag at T+1.
REQ-021 MISS_REQ: on be_addr handshake -> MISS_WAIT, be_addr_tvalid=0 next cycle.
REQ-022 MISS_WAIT: be_data_tready=1 (0 in all other states); on handshake, victim = lowest-index invalid slot, else slot at LRU position; victim gets tag, data, valid=1; victim promoted to MRU; -> RESP with fill data, thit=0.
REQ-023 RESP: on fe_data handshake -> IDLE; fe_data_tready low stalls indefinitely.
REQ-024 flush in IDLE SHALL clear all valid bits and set order[i]=i next cycle; flush has priority over fe_addr in the same cycle.
REQ-025 flush outside IDLE SHALL be latched as pending and applied on the cycle after returning to IDLE; the in-flight miss still fills and responds first.
REQ-026 Tag compare SHALL ignore invalid lines; after reset or flush all lookups miss.

Reset
REQ-027 rstn low: state IDLE, all valid bits 0, order[i]=i, flush pending 0, counters 0.
REQ-028 rstn low: fe_addr_tready, fe_data_tvalid, fe_data_thit, be_addr_tvalid, be_data_tready = 0; fe_data_tdata, be_addr_tdata = 0.
REQ-029 Reset mid-miss SHALL abandon the fill; backend data arriving after reset release SHALL be ignored (be_data_tready=0).

Configuration
REQ-030 Macro LRU_CACHE_STATS_EN defined: hit_cnt/miss_cnt ports exist; increment on each accepted hit/miss; saturate at 32'hFFFFFFFF; not cleared by flush.
REQ-031 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-032 Reset, lookup tag 0x10 -> miss; be_addr_tdata=0x10 at T+1; fill 0xAA.. -> fe_data_tdata=0xAA.., thit=0.
REQ-033 Repeat tag 0x10 -> fe_data_tvalid at T+1, thit=1, no be_addr_tvalid.
REQ-034 DEPTH=8: fill tags 1..8, hit 1, miss tag 9 -> tag 2 evicted; lookup 1 hits, 2 misses.
REQ-035 flush and fe_addr_tvalid (tag 1) same cycle in IDLE -> request not accepted; next cycle tag 1 misses.
REQ-036 Hold fe_data_tready=0 for 5 cycles in RESP, be_addr_tready=0 for 3 cycles in MISS_REQ -> outputs stable, no lost transfer.
REQ-037 STATS_EN: 3 misses + 2 hits -> miss_cnt=3, hit_cnt=2; pulse flush -> counts unchanged.
